// File: rtl/encoder16x4_queue_w_clk.sv
// Queued 16-to-4 priority encoder.
// Requests are merged into a pending set. Each request is handed out, one per
// accepted cycle, as a 4-bit code through a valid/ready output slot. The
// lowest index has the highest priority.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   inp      [0:15] request vector; bit i requests code i
//   load     merge inp into the pending set at the next edge
//   ready    downstream accepts outp when valid=1
//   outp     [3:0] registered code being offered
//   valid    outp holds a code that has not been accepted yet
//   pending  [0:15] registered pending-request set
//   busy     combinational: pending nonzero or valid
//   overflow registered one-cycle pulse when load hits an already pending bit
module encoder16x4_queue_w_clk (
    input  logic          clk,
    input  logic          rst,
    input  logic [0:15]   inp,
    input  logic          load,
    input  logic          ready,
    output logic [3:0]    outp,
    output logic          valid,
    output logic [0:15]   pending,
    output logic          busy,
    output logic          overflow
);

    localparam int unsigned NREQ = 16;
    localparam int unsigned CW   = 4;

    // Output slot state: empty, or holding an unaccepted code
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_VALID = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     outp_nxt;
    logic [0:NREQ-1]   pend_nxt;
    logic              ovf_nxt;

    logic [CW-1:0]     sel_c;
    logic              any_c;
    logic [0:NREQ-1]   clr_mask_c;
    logic              take_c;
    logic [0:NREQ-1]   pend_kept_c;

    // Lowest set index of the registered pending set wins
    always_comb begin
        sel_c = '0;
        any_c = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_c = CW'(i);
                any_c = 1'b1;
            end
        end
    end

    // One-hot mask for the bit being serviced
    always_comb begin
        clr_mask_c        = '0;
        clr_mask_c[sel_c] = 1'b1;
    end

    // Slot control: next state, next code, and whether a request is taken
    always_comb begin
        state_nxt = state;
        outp_nxt  = outp;
        take_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_c) begin
                    take_c    = 1'b1;
                    outp_nxt  = sel_c;
                    state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (ready) begin
                    if (any_c) begin
                        take_c   = 1'b1;
                        outp_nxt = sel_c;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pending update: clear the serviced bit, then OR in new requests so a
    // re-request of the serviced bit stays queued
    always_comb begin
        pend_kept_c = take_c ? (pending & ~clr_mask_c) : pending;
        pend_nxt    = load ? (pend_kept_c | inp) : pend_kept_c;
        ovf_nxt     = load & (|(inp & pending));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            outp     <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            outp     <= outp_nxt;
            pending  <= pend_nxt;
            overflow <= ovf_nxt;
        end
    end

    assign valid = (state == S_VALID);
    assign busy  = (|pending) | valid;

endmodule

// File: tb/tb_encoder16x4_queue_w_clk.sv
module tb_encoder16x4_queue_w_clk;

    logic        clk;
    logic        rst;
    logic [0:15] inp;
    logic        load;
    logic        ready;
    logic [3:0]  outp;
    logic        valid;
    logic [0:15] pending;
    logic        busy;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    encoder16x4_queue_w_clk dut (
        .clk      (clk),
        .rst      (rst),
        .inp      (inp),
        .load     (load),
        .ready    (ready),
        .outp     (outp),
        .valid    (valid),
        .pending  (pending),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending requests as a plain array of flags
    bit       m_p [16];
    bit       m_valid;
    int       m_outp;
    bit       m_ovf;

    task automatic model_reset();
        foreach (m_p[i]) m_p[i] = 1'b0;
        m_valid = 1'b0;
        m_outp  = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge(input bit ld, input logic [0:15] in, input bit rdy);
        int lowest;
        m_ovf = 1'b0;
        if (ld)
            for (int i = 0; i < 16; i++)
                if (in[i] && m_p[i]) m_ovf = 1'b1;
        if (!m_valid || rdy) begin
            lowest = -1;
            for (int i = 0; i < 16; i++)
                if (m_p[i] && lowest < 0) lowest = i;
            if (lowest >= 0) begin
                m_outp         = lowest;
                m_valid        = 1'b1;
                m_p[lowest]    = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (ld)
            for (int i = 0; i < 16; i++)
                if (in[i]) m_p[i] = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive inputs, take one edge, advance the model, then settle
    task automatic step(input bit ld, input logic [0:15] in, input bit rdy);
        load  = ld;
        inp   = in;
        ready = rdy;
        @(posedge clk);
        model_edge(ld, in, rdy);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [0:15] ep;
        bit          any;
        any = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ep[i] = m_p[i];
            if (m_p[i]) any = 1'b1;
        end
        chk({tag, ".valid"},    16'(valid),    16'(m_valid));
        if (m_valid) chk({tag, ".outp"}, 16'(outp), 16'(m_outp));
        chk({tag, ".pending"},  16'(pending),  16'(ep));
        chk({tag, ".busy"},     16'(busy),     16'(any | m_valid));
        chk({tag, ".overflow"}, 16'(overflow), 16'(m_ovf));
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("rst.outp",     16'(outp),     16'd0);
        chk("rst.valid",    16'(valid),    16'd0);
        chk("rst.pending",  16'(pending),  16'd0);
        chk("rst.busy",     16'(busy),     16'd0);
        chk("rst.overflow", 16'(overflow), 16'd0);
        #1 rst = 1'b1;
    endtask

    typedef struct {
        logic        ld;
        logic [0:15] in;
        logic        rdy;
        logic [3:0]  eo;
        logic        ev;
        logic [0:15] ep;
        logic        eov;
    } vec_t;

    vec_t tbl [18];

    initial begin
        logic [0:15] oh;
        logic [0:15] dec;
        logic [0:15] rin;

        // bit 0 alone; bits 3 and 9 stalled; duplicate bit 5; empty load
        tbl[0]  = '{1'b1, 16'h8000, 1'b1, 4'd0, 1'b0, 16'h8000, 1'b0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 4'd0, 1'b1, 16'h0000, 1'b0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0};
        tbl[3]  = '{1'b1, 16'h1040, 1'b0, 4'd0, 1'b0, 16'h1040, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 4'd3, 1'b1, 16'h0040, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 4'd3, 1'b1, 16'h0040, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 4'd3, 1'b1, 16'h0040, 1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 4'd3, 1'b1, 16'h0040, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 4'd3, 1'b1, 16'h0040, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 4'd9, 1'b1, 16'h0000, 1'b0};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 4'd9, 1'b0, 16'h0000, 1'b0};
        tbl[11] = '{1'b1, 16'h8400, 1'b0, 4'd9, 1'b0, 16'h8400, 1'b0};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h0400, 1'b0};
        tbl[13] = '{1'b1, 16'h2400, 1'b0, 4'd0, 1'b1, 16'h2400, 1'b1};
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 4'd2, 1'b1, 16'h0400, 1'b0};
        tbl[15] = '{1'b0, 16'h0000, 1'b1, 4'd5, 1'b1, 16'h0000, 1'b0};
        tbl[16] = '{1'b0, 16'h0000, 1'b1, 4'd5, 1'b0, 16'h0000, 1'b0};
        tbl[17] = '{1'b1, 16'h0000, 1'b1, 4'd5, 1'b0, 16'h0000, 1'b0};

        rst   = 1'b0;
        load  = 1'b0;
        inp   = '0;
        ready = 1'b0;
        model_reset();
        #12;
        do_reset();

        for (int k = 0; k < 18; k++) begin
            step(tbl[k].ld, tbl[k].in, tbl[k].rdy);
            chk($sformatf("tbl%0d.outp", k),     16'(outp),     16'(tbl[k].eo));
            chk($sformatf("tbl%0d.valid", k),    16'(valid),    16'(tbl[k].ev));
            chk($sformatf("tbl%0d.pending", k),  16'(pending),  16'(tbl[k].ep));
            chk($sformatf("tbl%0d.busy", k),     16'(busy),     16'((|tbl[k].ep) | tbl[k].ev));
            chk($sformatf("tbl%0d.overflow", k), 16'(overflow), 16'(tbl[k].eov));
        end

        // Full drain: codes 0..15 with no bubble
        step(1'b1, 16'hFFFF, 1'b1);
        check_model("full.load");
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 16'h0000, 1'b1);
            chk($sformatf("full.code%0d", k), 16'(outp), 16'(k));
            chk($sformatf("full.valid%0d", k), 16'(valid), 16'd1);
        end
        step(1'b0, 16'h0000, 1'b1);
        chk("full.end_valid",   16'(valid),   16'd0);
        chk("full.end_pending", 16'(pending), 16'd0);

        // Reset mid-drain discards everything
        step(1'b1, 16'hFFFF, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 16'h0000, 1'b1);
            chk($sformatf("mid.code%0d", k), 16'(outp), 16'(k));
        end
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 16'h0000, 1'b1);
            chk($sformatf("mid.idle_valid%0d", k), 16'(valid), 16'd0);
            chk($sformatf("mid.idle_busy%0d", k),  16'(busy),  16'd0);
        end

        // Single-bit sweep, code decoded back to one-hot
        for (int i = 0; i < 16; i++) begin
            oh    = '0;
            oh[i] = 1'b1;
            step(1'b1, oh, 1'b1);
            step(1'b0, 16'h0000, 1'b1);
            chk($sformatf("sweep%0d.code", i), 16'(outp), 16'(i));
            dec       = '0;
            dec[outp] = 1'b1;
            chk($sformatf("sweep%0d.decode", i), 16'(dec), 16'(oh));
            step(1'b0, 16'h0000, 1'b1);
            chk($sformatf("sweep%0d.idle", i), 16'(valid), 16'd0);
        end

        // Random traffic against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rin = 16'($urandom & $urandom & $urandom);
            step(1'($urandom_range(0, 2) == 0), rin, 1'($urandom_range(0, 9) < 7));
            check_model($sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encoder16x4_queue_w_clk.md
ENCODER16X4_QUEUE_W_CLK -- requirements
Module: encoder16x4_queue_w_clk

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 16 request lines and a 4-bit code.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-004 inp  input  [0:15]  request vector, bit i requests code i, same bit order as the decoder output.
REQ-005 load  input  1  when 1 at a rising edge, inp is merged into the pending set.
REQ-006 ready  input  1  downstream accepts code when valid=1 and ready=1 at a rising edge.
REQ-007 outp  output  [3:0]  registered binary code of the serviced request.
REQ-008 valid  output  1  outp holds a code not yet accepted.
REQ-009 pending  output  [0:15]  registered pending-request set.
REQ-010 busy  output  1  combinational: 1 when pending is nonzero or valid=1.
REQ-011 overflow  output  1  registered one-cycle pulse on a duplicate request.

Function
REQ-012 Pending set P SHALL be a 16-bit register; P[i]=1 means code i is waiting.
REQ-013 Output slot SHALL be free in a cycle when valid=0, or valid=1 and ready=1.
REQ-014 When slot is free and P nonzero, the block SHALL select the lowest set index i of P (index 0 highest priority), load outp<=i, valid<=1, clear P[i] at that edge.
REQ-015 When slot is free and P is zero, valid SHALL go to 0 at that edge; outp SHALL keep its last value.
REQ-016 While valid=1 and ready=0, outp and valid SHALL hold unchanged and P SHALL not be decremented.
REQ-017 Selection SHALL use P as registered before the edge; bits loaded at edge k are first eligible at edge k+1.
REQ-018 Latency: inp loaded at edge k into an empty, idle block SHALL give valid=1 with its code after edge k+1.
REQ-019 On load, P next SHALL equal (P with the serviced bit cleared) OR inp; a simultaneous load of the serviced bit SHALL keep it set (re-request serviced again).
REQ-020 overflow SHALL be 1 for exactly the cycle after an edge where load=1 and inp AND P (pre-edge) is nonzero; duplicate bits are absorbed, not counted.
REQ-021 load=1 with inp=0 SHALL leave P unchanged and raise no overflow.
REQ-022 Back-to-back acceptance (ready held 1) SHALL deliver one code per cycle with no bubble until P empties.
REQ-023 All 16 bits set SHALL drain as codes 0,1,...,15 in order over 16 accepted cycles.

Reset
REQ-024 rst=0 SHALL asynchronously force outp=0, valid=0, pending=0, overflow=0; busy becomes 0.
REQ-025 Reset asserted mid-drain SHALL discard all pending requests and any unaccepted code; no code SHALL appear after release until a new load.
REQ-026 First state update after rst returns high SHALL occur at the next rising clk edge.

Verification
REQ-027 Reset, load inp=16'h8000 (bit 0 only), ready=1 -> after next edge valid=1, outp=0; following edge valid=0, busy=0.
REQ-028 Load inp=16'hFFFF, ready=1 -> outp sequence 0..15 on 16 consecutive cycles, then valid=0, pending=0.
REQ-029 Load bits 3 and 9, ready=0 for 5 cycles -> outp=3 held, valid=1, pending shows bit 9 only; raise ready -> outp=9 next cycle.
REQ-030 P holds bit 5, load inp with bit 5 and bit 2 -> overflow=1 one cycle, pending = bits 2 and 5, codes 2 then 5 delivered.
REQ-031 Load inp=16'hFFFF, accept 4 codes, assert rst=0 between edges -> outputs zero immediately; after release and idle cycles valid stays 0.
REQ-032 Sweep: for i=0..15 load single bit i with ready=1 -> outp=i, each feeding the 4x16 decoder returns the original one-hot vector.
